// File: rtl/timer_counter.sv
// Memory-mapped timer/counter (TC0/TC1) with an IDLE/LOAD/CNT/INT countdown FSM and a registered IRQ.
// Optional build macro TC_PRESCALE_EN adds a PRESCALE register at offset 3 that slows the count rate.
module timer_counter #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t r_state, w_next;

  logic        r_en, r_im;
  logic [1:0]  r_mode;
  logic [31:0] r_preset, r_count, w_count_nxt;
  logic        r_irq_flag;

  logic w_wr_ctrl, w_wr_preset, w_en_eff, w_step;
  logic w_set_irq, w_clr_irq_auto, w_fsm_clr_en;
  logic [PRESCALE_W-1:0] w_prescale_rd;
  logic w_addr_unused;

  assign w_addr_unused = ^Addr[29:2];

  assign w_wr_ctrl   = WE && (Addr[1:0] == 2'd0);
  assign w_wr_preset = WE && (Addr[1:0] == 2'd1);
  // A CTRL write in the same cycle decides whether CNT keeps running,
  // so a stop write freezes COUNT at the value visible when it is issued.
  assign w_en_eff    = w_wr_ctrl ? Din[0] : r_en;

`ifdef TC_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_prescale, r_div;
  logic                  w_wr_prescale;

  assign w_wr_prescale = WE && (Addr[1:0] == 2'd3);
  assign w_step        = (r_div == r_prescale);
  assign w_prescale_rd = r_prescale;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_div      <= '0;
    end else begin
      if (w_wr_prescale) r_prescale <= Din[PRESCALE_W-1:0];
      // Divider only advances while counting; any step, LOAD or exit restarts it.
      if (r_state == S_CNT && w_en_eff && !w_step) r_div <= r_div + 1'b1;
      else                                         r_div <= '0;
    end
  end
`else
  assign w_step        = 1'b1;
  assign w_prescale_rd = '0;
`endif

  always_comb begin
    w_next         = r_state;
    w_count_nxt    = r_count;
    w_set_irq      = 1'b0;
    w_clr_irq_auto = 1'b0;
    w_fsm_clr_en   = 1'b0;
    case (r_state)
      S_IDLE: if (r_en) w_next = S_LOAD;
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_next      = S_CNT;
      end
      S_CNT: begin
        if (!w_en_eff) begin
          w_next = S_IDLE;
        end else if (w_step) begin
          if (r_count > 32'd1) begin
            w_count_nxt = r_count - 32'd1;
          end else begin
            w_count_nxt = '0;
            w_next      = S_INT;
            w_set_irq   = 1'b1;
          end
        end
      end
      S_INT: begin
        w_next = S_IDLE;
        if (r_mode == 2'b01) w_clr_irq_auto = 1'b1;
        else                 w_fsm_clr_en   = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_mode     <= 2'b00;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_nxt;
      if (w_wr_ctrl) begin
        r_en   <= Din[0];
        r_mode <= Din[2:1];
        r_im   <= Din[3];
      end else if (w_fsm_clr_en) begin
        r_en <= 1'b0;
      end
      if (w_wr_preset) r_preset <= Din;
      // Entering INT wins over a coincident CTRL write so no interrupt is lost.
      if (w_set_irq)                        r_irq_flag <= 1'b1;
      else if (w_wr_ctrl || w_clr_irq_auto) r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[1:0])
      2'd0: Dout = {28'd0, r_im, r_mode, r_en};
      2'd1: Dout = r_preset;
      2'd2: Dout = r_count;
      2'd3: Dout = {{(32-PRESCALE_W){1'b0}}, w_prescale_rd};
      default: Dout = '0;
    endcase
  end

  assign IRQ = r_irq_flag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, mask/stop and boundary cases.
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  timer_counter #(.PRESCALE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [29:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    #5;
    reset_n = 1'b0;
    #3;
    chk_rd("por_ctrl", 30'd0, 32'd0);
    chk("por_irq", {31'd0, IRQ}, 32'd0);
    reset_n = 1'b1;

    // Reset mid-count aborts immediately
    wr(30'd1, 32'd100);
    wr(30'd0, 32'h9);
    tick(10);
    chk_rd("run_count", 30'd2, 32'd92);
    reset_n = 1'b0;
    #1;
    chk_rd("rst_ctrl", 30'd0, 32'd0);
    chk_rd("rst_preset", 30'd1, 32'd0);
    chk_rd("rst_count", 30'd2, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    reset_n = 1'b1;
    tick(110);
    chk("rst_irq_after", {31'd0, IRQ}, 32'd0);
    chk_rd("rst_count_after", 30'd2, 32'd0);

    // One-shot: PRESET=5, CTRL=0x9
    do_reset();
    wr(30'd1, 32'd5);
    wr(30'd0, 32'h9);             // e0
    tick(2);                      // e2
    for (int k = 0; k < 5; k++) begin
      chk_rd("os_count", 30'd2, 32'd5 - k);
      chk("os_irq_low", {31'd0, IRQ}, 32'd0);
      tick();
    end
    chk("os_irq_e7", {31'd0, IRQ}, 32'd1);  // e7
    chk_rd("os_count_e7", 30'd2, 32'd0);
    tick();                       // e8
    chk_rd("os_ctrl_e8", 30'd0, 32'h8);
    chk("os_irq_e8", {31'd0, IRQ}, 32'd1);
    tick(5);
    chk("os_irq_hold", {31'd0, IRQ}, 32'd1);
    wr(30'd0, 32'h8);
    chk("os_irq_clr", {31'd0, IRQ}, 32'd0);

    // Auto-reload: PRESET=2 -> period 5, IRQ at e4, e9, e14, e19
    do_reset();
    wr(30'd1, 32'd2);
    wr(30'd0, 32'hB);             // e0
    for (int c = 1; c <= 21; c++) begin
      tick();
      chk("ar_irq", {31'd0, IRQ}, (c >= 4 && ((c - 4) % 5) == 0) ? 32'd1 : 32'd0);
    end

    // Masked: flag sets, IRQ stays low
    do_reset();
    wr(30'd1, 32'd3);
    wr(30'd0, 32'h1);             // e0
    tick(5);                      // e5 = INT
    chk("mask_irq", {31'd0, IRQ}, 32'd0);
    chk("mask_flag", {31'd0, dut.r_irq_flag}, 32'd1);
    tick(3);
    chk("mask_flag_hold", {31'd0, dut.r_irq_flag}, 32'd1);
    chk_rd("mask_ctrl", 30'd0, 32'd0);

    // Stop at COUNT=7
    do_reset();
    wr(30'd1, 32'd10);
    wr(30'd0, 32'h9);             // e0
    tick(5);                      // e5, COUNT=7
    chk_rd("stop_pre", 30'd2, 32'd7);
    wr(30'd0, 32'h0);
    chk_rd("stop_count", 30'd2, 32'd7);
    chk("stop_state", {30'd0, dut.r_state}, 32'd0);
    tick(12);
    chk_rd("stop_frozen", 30'd2, 32'd7);
    chk("stop_irq", {31'd0, IRQ}, 32'd0);

    // PRESET=0 -> INT at e3
    do_reset();
    wr(30'd0, 32'h9);             // e0
    tick(2);
    chk("p0_irq_e2", {31'd0, IRQ}, 32'd0);
    tick();
    chk("p0_irq_e3", {31'd0, IRQ}, 32'd1);

    // COUNT not writable; CTRL upper bits read 0
    do_reset();
    wr(30'd2, 32'hFFFF);
    chk_rd("count_ro", 30'd2, 32'd0);
    wr(30'd0, 32'hFFFF_FFF6);
    chk_rd("ctrl_hi0", 30'd0, 32'h6);

    // PRESET change mid-count applies at next reload
    do_reset();
    wr(30'd1, 32'd4);
    wr(30'd0, 32'hB);             // e0
    tick(2);                      // e2
    chk_rd("pc_e2", 30'd2, 32'd4);
    wr(30'd1, 32'd1);             // e3
    chk_rd("pc_e3", 30'd2, 32'd3);
    tick(3);                      // e6
    chk("pc_irq_e6", {31'd0, IRQ}, 32'd1);
    tick();                       // e7
    chk("pc_irq_e7", {31'd0, IRQ}, 32'd0);
    tick(2);                      // e9
    chk_rd("pc_reload", 30'd2, 32'd1);
    tick();                       // e10
    chk("pc_irq_e10", {31'd0, IRQ}, 32'd1);

    // Upper address bits ignored
    do_reset();
    wr({28'hABCDEF1, 2'b01}, 32'h1234_5678);
    chk_rd("addr_lo", 30'd1, 32'h1234_5678);
    chk_rd("addr_hi", {28'hFFFFFFF, 2'b01}, 32'h1234_5678);

`ifdef TC_PRESCALE_EN
    do_reset();
    wr(30'd3, 32'd2);
    chk_rd("ps_rd", 30'd3, 32'd2);
    wr(30'd1, 32'd3);
    wr(30'd0, 32'h9);             // e0
    tick(2);                      // CNT entry
    chk_rd("ps_c0", 30'd2, 32'd3);
    tick(3);
    chk_rd("ps_c3", 30'd2, 32'd2);
    tick(3);
    chk_rd("ps_c6", 30'd2, 32'd1);
    tick(2);
    chk("ps_irq_c8", {31'd0, IRQ}, 32'd0);
    tick();
    chk("ps_irq_c9", {31'd0, IRQ}, 32'd1);
`else
    do_reset();
    wr(30'd3, 32'h5);
    chk_rd("off3_zero", 30'd3, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
